// File: rtl/hit_timer.sv
// Shot timer: stamps each channel's first rising det relative to the earliest hit
// in the shot, with a bounded capture window and a registered select/data readout.
module hit_timer #(
  parameter int NCH     = 4,
  parameter int TW      = 16,
  parameter int TIMEOUT = 8000
) (
  input  logic                   clk8M,
  input  logic                   reset_n,
  input  logic                   arm,
  input  logic                   clear,
  input  logic [NCH-1:0]         det,
  input  logic [$clog2(NCH):0]   rd_sel,
  output logic [TW-1:0]          rd_stamp,
  output logic                   rd_valid,
  output logic [NCH-1:0]         hit_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout
);

  localparam int              IDXW      = $clog2(NCH);
  localparam int              SELW      = IDXW + 1;
  localparam logic [SELW-1:0] NCH_SEL   = SELW'(NCH);
  localparam logic [TW-1:0]   TIMEOUT_C = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t          state;
  logic [TW-1:0]   counter;
  logic [NCH-1:0]  det_q;
  logic [TW-1:0]   stamp [NCH];

  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  new_hit;
  logic [NCH-1:0]  mask_next;

  // A level already high when the shot is armed never looks like a rise.
  assign rise      = det & ~det_q;
  assign new_hit   = rise & ~hit_mask;
  assign mask_next = hit_mask | new_hit;

  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

  always_ff @(posedge clk8M or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= '0;
      det_q    <= '0;
      hit_mask <= '0;
      timeout  <= '0;
      for (int i = 0; i < NCH; i++) stamp[i] <= '0;
    end else begin
      det_q <= det;
      if (clear) begin
        state    <= IDLE;
        counter  <= '0;
        hit_mask <= '0;
        timeout  <= '0;
        for (int i = 0; i < NCH; i++) stamp[i] <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              state    <= ARMED;
              hit_mask <= '0;
              timeout  <= '0;
              for (int i = 0; i < NCH; i++) stamp[i] <= '0;
            end
          end
          ARMED: begin
            if (|rise) begin
              hit_mask <= rise;
              for (int i = 0; i < NCH; i++) if (rise[i]) stamp[i] <= '0;
              if (&rise) begin
                state   <= DONE;
                counter <= '0;
              end else begin
                state   <= CAPTURE;
                counter <= TW'(1);
              end
            end
          end
          CAPTURE: begin
            for (int i = 0; i < NCH; i++) if (new_hit[i]) stamp[i] <= counter;
            hit_mask <= mask_next;
            // Completion outranks expiry when both land on the same cycle.
            if (&mask_next) begin
              state   <= DONE;
              counter <= '0;
              timeout <= 1'b0;
            end else if (counter == TIMEOUT_C) begin
              state   <= DONE;
              counter <= '0;
              timeout <= 1'b1;
            end else begin
              counter <= counter + TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk8M or negedge reset_n) begin
    if (!reset_n) begin
      rd_stamp <= '0;
      rd_valid <= 1'b0;
    end else if (rd_sel < NCH_SEL) begin
      rd_stamp <= stamp[rd_sel[IDXW-1:0]];
      rd_valid <= hit_mask[rd_sel[IDXW-1:0]];
    end else begin
      rd_stamp <= '0;
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hit_timer.sv
// Directed bench for hit_timer: a vector table of held inputs and expected outputs,
// plus hand-written sequences for the long capture-window cases.
module tb_hit_timer;

  logic        clk8M;
  logic        reset_n;
  logic        arm;
  logic        clear;
  logic [3:0]  det;
  logic [2:0]  rd_sel;
  logic [15:0] rd_stamp;
  logic        rd_valid;
  logic [3:0]  hit_mask;
  logic        busy;
  logic        done;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  hit_timer #(.NCH(4), .TW(16), .TIMEOUT(8000)) dut (
    .clk8M    (clk8M),
    .reset_n  (reset_n),
    .arm      (arm),
    .clear    (clear),
    .det      (det),
    .rd_sel   (rd_sel),
    .rd_stamp (rd_stamp),
    .rd_valid (rd_valid),
    .hit_mask (hit_mask),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout)
  );

  initial clk8M = 1'b0;
  always #5 clk8M = ~clk8M;

  typedef struct {
    logic        arm;
    logic        clear;
    logic [3:0]  det;
    logic [2:0]  sel;
    int          ncyc;
    logic        chk_rd;
    logic        busy;
    logic        done;
    logic        tmo;
    logic [3:0]  mask;
    logic        rv;
    logic [15:0] rs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic a, logic c, logic [3:0] d, logic [2:0] s, int n,
                              logic cr, logic b, logic dn, logic t, logic [3:0] m,
                              logic rv, logic [15:0] rs);
    vec_t v;
    v.arm = a; v.clear = c; v.det = d; v.sel = s; v.ncyc = n; v.chk_rd = cr;
    v.busy = b; v.done = dn; v.tmo = t; v.mask = m; v.rv = rv; v.rs = rs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk8M);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] s, input logic v, input logic [15:0] st);
    rd_sel = s;
    step(1);
    chk({name, " rd"}, 32'({rd_valid, rd_stamp}), 32'({v, st}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // {arm, clear, det, sel, ncyc, chk_rd, busy, done, tmo, mask, rd_valid, rd_stamp}
    // Shot 1: ch2 @0, ch0 @3, ch3 @10, ch1 @25
    vecs.push_back(mk(0,0,4'b0000,0, 1,1, 0,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(1,0,4'b0000,0, 1,0, 1,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0100,0, 1,0, 1,0,0,4'b0100, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0100,0, 2,0, 1,0,0,4'b0100, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0101,0, 1,0, 1,0,0,4'b0101, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0101,0, 6,0, 1,0,0,4'b0101, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1101,0, 1,0, 1,0,0,4'b1101, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1101,0,14,0, 1,0,0,4'b1101, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1111,0, 1,0, 0,1,0,4'b1111, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0000,2, 1,1, 0,1,0,4'b1111, 1,16'd0));
    vecs.push_back(mk(0,0,4'b0000,0, 1,1, 0,1,0,4'b1111, 1,16'd3));
    vecs.push_back(mk(0,0,4'b0000,3, 1,1, 0,1,0,4'b1111, 1,16'd10));
    vecs.push_back(mk(0,0,4'b0000,1, 1,1, 0,1,0,4'b1111, 1,16'd25));
    vecs.push_back(mk(0,0,4'b0000,4, 1,1, 0,1,0,4'b1111, 0,16'd0));
    // Shot 2: det[0] high before arm; ch1 @0, ch2 @5, ch3 @7, ch0 re-rises @40; arm in CAPTURE ignored
    vecs.push_back(mk(0,0,4'b0001,0, 1,0, 0,1,0,4'b1111, 0,16'd0));
    vecs.push_back(mk(1,0,4'b0001,0, 1,0, 1,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0011,0, 1,0, 1,0,0,4'b0010, 0,16'd0));
    vecs.push_back(mk(1,0,4'b0011,0, 4,0, 1,0,0,4'b0010, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0111,0, 1,0, 1,0,0,4'b0110, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0111,0, 1,0, 1,0,0,4'b0110, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1111,0, 1,0, 1,0,0,4'b1110, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1111,0,12,0, 1,0,0,4'b1110, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1110,0,20,0, 1,0,0,4'b1110, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1111,0, 1,0, 0,1,0,4'b1111, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0000,0, 1,1, 0,1,0,4'b1111, 1,16'd40));
    vecs.push_back(mk(0,0,4'b0000,1, 1,1, 0,1,0,4'b1111, 1,16'd0));
    vecs.push_back(mk(0,0,4'b0000,2, 1,1, 0,1,0,4'b1111, 1,16'd5));
    vecs.push_back(mk(0,0,4'b0000,3, 1,1, 0,1,0,4'b1111, 1,16'd7));
    // Shot 3: all channels rise together straight from ARMED
    vecs.push_back(mk(1,0,4'b0000,0, 1,0, 1,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1111,0, 1,0, 0,1,0,4'b1111, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0000,3, 1,1, 0,1,0,4'b1111, 1,16'd0));
    // Shot 4: ch0 @0, ch2 pulses @4 and @9, live readout of ch2
    vecs.push_back(mk(1,0,4'b0000,0, 1,0, 1,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0001,0, 1,0, 1,0,0,4'b0001, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0001,0, 3,0, 1,0,0,4'b0001, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0101,0, 1,0, 1,0,0,4'b0101, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0001,0, 4,0, 1,0,0,4'b0101, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0101,0, 1,0, 1,0,0,4'b0101, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0101,2, 1,1, 1,0,0,4'b0101, 1,16'd4));
    // Shot 5: clear, re-arm, ch3 @0, clear+arm together @6
    vecs.push_back(mk(0,1,4'b0000,0, 1,0, 0,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(1,0,4'b0000,0, 1,0, 1,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1000,0, 1,0, 1,0,0,4'b1000, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1000,0, 5,0, 1,0,0,4'b1000, 0,16'd0));
    vecs.push_back(mk(1,1,4'b1001,0, 1,0, 0,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(0,0,4'b1001,3, 1,1, 0,0,0,4'b0000, 0,16'd0));
    vecs.push_back(mk(0,0,4'b0000,4, 1,1, 0,0,0,4'b0000, 0,16'd0));

    arm = 1'b0; clear = 1'b0; det = 4'b0000; rd_sel = 3'd0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk8M);
    #1;
    chk("reset state", 32'({busy, done, timeout, hit_mask, rd_valid, rd_stamp}), 32'(0));
    @(negedge clk8M);
    reset_n = 1'b1;
    step(1);

    for (int i = 0; i < vecs.size(); i++) begin
      arm = vecs[i].arm; clear = vecs[i].clear; det = vecs[i].det; rd_sel = vecs[i].sel;
      step(vecs[i].ncyc);
      chk($sformatf("vec%0d status", i), 32'({busy, done, timeout, hit_mask}),
          32'({vecs[i].busy, vecs[i].done, vecs[i].tmo, vecs[i].mask}));
      if (vecs[i].chk_rd)
        chk($sformatf("vec%0d", i), 32'({rd_valid, rd_stamp}), 32'({vecs[i].rv, vecs[i].rs}));
    end
    arm = 1'b0; clear = 1'b0;

    // Window expiry: ch1 and ch3 together, nothing else
    det = 4'b0000; arm = 1'b1; rd_sel = 3'd0;
    step(1);
    arm = 1'b0; det = 4'b1010;
    step(1);
    chk("expiry first hit", 32'({busy, done, hit_mask}), 32'({1'b1, 1'b0, 4'b1010}));
    n = 0;
    while (!done && n < 9000) begin
      step(1);
      n++;
    end
    chk("expiry cycles", 32'(n), 32'd8000);
    chk("expiry status", 32'({busy, done, timeout, hit_mask}), 32'({1'b0, 1'b1, 1'b1, 4'b1010}));
    rd_chk("expiry ch0", 3'd0, 1'b0, 16'd0);
    rd_chk("expiry ch1", 3'd1, 1'b1, 16'd0);
    rd_chk("expiry ch2", 3'd2, 1'b0, 16'd0);
    rd_chk("expiry ch3", 3'd3, 1'b1, 16'd0);

    // Completion on the very cycle the window expires
    det = 4'b0000; arm = 1'b1;
    step(1);
    arm = 1'b0; det = 4'b0001;
    step(1);
    step(7999);
    chk("edge pre-expiry", 32'({busy, done, hit_mask}), 32'({1'b1, 1'b0, 4'b0001}));
    det = 4'b1111;
    step(1);
    chk("edge complete", 32'({busy, done, timeout, hit_mask}), 32'({1'b0, 1'b1, 1'b0, 4'b1111}));
    rd_chk("edge ch1", 3'd1, 1'b1, 16'd8000);
    rd_chk("edge ch0", 3'd0, 1'b1, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_timer.md
Name: hit_timer

Overview:
- Consumes the registered slope-detect flags from the per-sensor slope detectors, all on the 8 MHz domain.
- Records, for each channel, the arrival time of its first detection relative to the earliest detection in the shot.
- Results are held in a small register file and read out by the host-side logic through a select/data port.
- This block is the downstream reader of the slope detectors' det outputs; the solver uses the timestamp differences.

Parameters:
- NCH, 4, number of sensor channels (det inputs).
- TW, 16, timestamp and counter width in bits.
- TIMEOUT, 8000, capture window in clk8M cycles after the first hit (1 ms at 8 MHz); must be less than 2^TW.

Ports:
- clk8M  input  1  8 MHz system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- arm  input  1  single-cycle request to start a new shot capture.
- clear  input  1  single-cycle request to abort or clear and return to IDLE.
- det  input  NCH  per-channel slope-detect flags, synchronous to clk8M.
- rd_sel  input  $clog2(NCH)+1  readout channel select.
- rd_stamp  output  TW  timestamp of the selected channel, registered.
- rd_valid  output  1  selected channel has a captured stamp, registered.
- hit_mask  output  NCH  per-channel captured flags.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  high in DONE.
- timeout  output  1  DONE was reached by window expiry rather than all channels hit.

Behaviour:
- Reset (async, reset_n low):
  - State is IDLE; counter, all stamps, hit_mask, det_q, rd_stamp, rd_valid, done, busy and timeout are 0.
- Edge detect:
  - det_q <= det every cycle in every state.
  - rise = det & ~det_q.
  - A det held high continuously produces no rise. A det already high when arm is asserted is not a hit until it falls and rises again.
- State machine (registered; clear has priority over everything):
  - IDLE:
    - arm -> ARMED; stamps, hit_mask and timeout are zeroed in the same cycle.
  - ARMED:
    - Any rise -> CAPTURE.
    - Every channel with rise in that cycle gets stamp = 0 and its hit_mask bit set.
    - counter <= 1.
    - If all NCH channels rise in that same cycle -> DONE directly, with timeout = 0.
  - CAPTURE:
    - counter increments by 1 per cycle.
    - A channel with rise and no hit_mask bit gets stamp <= counter and its hit_mask bit set.
    - Later rises on an already-captured channel are ignored: first hit wins.
    - When every hit_mask bit is set (including bits set this cycle) -> DONE, timeout = 0.
    - Otherwise, when counter == TIMEOUT and no completion occurs this cycle -> DONE, timeout = 1. A rise in the counter == TIMEOUT cycle is still captured with stamp TIMEOUT.
    - Completion and timeout in the same cycle resolves to DONE with timeout = 0.
  - DONE:
    - Stamps, hit_mask and timeout are held.
    - arm -> ARMED, zeroing stamps, hit_mask and timeout as in IDLE.
  - clear, in any state:
    - Next state IDLE; stamps, hit_mask, counter and timeout are zeroed.
    - If clear and arm are asserted together, clear wins and arm is dropped.
  - arm in ARMED or CAPTURE is ignored.
- Counter:
  - Held at 0 outside CAPTURE.
  - Never wraps, because TIMEOUT < 2^TW.
- Outputs:
  - busy = (ARMED or CAPTURE); done = (state == DONE). Both are decoded from the state register.
- Readout:
  - 1-cycle latency: rd_stamp <= stamp[rd_sel] and rd_valid <= hit_mask[rd_sel].
  - rd_sel >= NCH returns rd_stamp = 0 and rd_valid = 0.
  - Readout is legal in any state. During CAPTURE it returns the live values.

Test Plan:
- Reset with det = 4'b0000, then arm; det rises on ch2 at cycle T0, ch0 at T0+3, ch3 at T0+10, ch1 at T0+25 -> stamps ch2 = 0, ch0 = 3, ch3 = 10, ch1 = 25; done = 1 at T0+26; timeout = 0; busy = 0.
- Arm; ch1 and ch3 rise in the same cycle, then nothing else for 8000 cycles -> stamps ch1 = ch3 = 0; hit_mask = 4'b1010; done with timeout = 1 exactly when counter reaches 8000; rd_valid = 0 for ch0 and ch2.
- Hold det[0] high before arm and through the shot; ch1–ch3 rise at 0/5/7; det[0] falls then rises at cycle 40 -> ch0 stamp = 40; pre-arm high level not counted.
- Double pulse on ch2 at cycles 4 and 9 during CAPTURE -> ch2 stamp = 4, second pulse ignored.
- Assert clear at cycle 6 of CAPTURE together with arm -> state IDLE next cycle; hit_mask = 0; stamps = 0; busy = 0; arm ignored.
- rd_sel = 4 (out of range, NCH = 4) -> rd_stamp = 0 and rd_valid = 0 one cycle later; rd_sel = 2 returns ch2 data with 1-cycle latency.
